// File: rtl/pic_input_conditioner.sv
// Input-pin conditioner: per-pin synchroniser and debouncer, registered edge pulses,
// and sticky maskable edge-event flags with a combined interrupt request.
module pic_input_conditioner #(
    parameter int   WIDTH       = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 16,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] pin_raw,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] pin_q,
    output logic [WIDTH-1:0] rise_p,
    output logic [WIDTH-1:0] fall_p,
    output logic [WIDTH-1:0] evt_flag,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] pin_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] set_v;
    logic [WIDTH-1:0] flag_d;

    assign s = sync_p0[SYNC_STAGES-1];

    // Stage 0: synchroniser chain, free-running regardless of ena
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p0[k] <= {WIDTH{RESET_LEVEL}};
            end
        end else begin
            sync_p0[0] <= pin_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p0[k] <= sync_p0[k-1];
            end
        end
    end

    always_comb begin
        pin_d  = pin_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ena) begin
                if (s[i] == pin_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    cnt_d[i]  = '0;
                    pin_d[i]  = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // The flag sets on the edge that raises a pulse and is re-asserted while the
        // pulse is visible, so a clear coinciding with the pulse loses to the set.
        set_v  = ena ? (((rise_d | rise_p) & rise_en) | ((fall_d | fall_p) & fall_en))
                     : '0;
        flag_d = set_v | (evt_flag & ~evt_clr);
    end

    // Stage 1: debounced level, counters, pulses, flags and irq
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            pin_q    <= {WIDTH{RESET_LEVEL}};
            rise_p   <= '0;
            fall_p   <= '0;
            evt_flag <= '0;
            irq      <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pin_q    <= pin_d;
            rise_p   <= rise_d;
            fall_p   <= fall_d;
            evt_flag <= flag_d;
            irq      <= |flag_d;
        end
    end

endmodule

// File: tb/tb_pic_input_conditioner.sv
// Bench for pic_input_conditioner: directed scenarios followed by randomized pin
// activity, all compared against a cycle-level behavioural model.
module tb_pic_input_conditioner;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 16;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [W-1:0] pin_raw;
    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic [W-1:0] evt_clr;
    logic [W-1:0] pin_q;
    logic [W-1:0] rise_p;
    logic [W-1:0] fall_p;
    logic [W-1:0] evt_flag;
    logic         irq;

    int compared   = 0;
    int mismatched = 0;

    pic_input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pin_raw(pin_raw),
        .rise_en(rise_en), .fall_en(fall_en), .evt_clr(evt_clr),
        .pin_q(pin_q), .rise_p(rise_p), .fall_p(fall_p),
        .evt_flag(evt_flag), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a pad value is seen SYNC edges after it is applied; a level is
    // accepted once it has disagreed with the clean level on DEB consecutive enabled edges.
    logic [W-1:0] m_pipe [SYNC];
    int           m_run  [W];
    logic [W-1:0] m_q, m_rise, m_fall, m_flag;
    logic         m_irq;

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
        for (int b = 0; b < W; b++) m_run[b] = 0;
        m_q = '0; m_rise = '0; m_fall = '0; m_flag = '0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [W-1:0] seen, nr, nf, setv;
        seen = m_pipe[SYNC-1];
        for (int k = SYNC-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = pin_raw;
        nr = '0;
        nf = '0;
        if (ena) begin
            for (int b = 0; b < W; b++) begin
                if (seen[b] != m_q[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == DEB) begin
                        m_q[b]   = seen[b];
                        m_run[b] = 0;
                        if (seen[b]) nr[b] = 1'b1;
                        else         nf[b] = 1'b1;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
        setv   = ena ? (((nr | m_rise) & rise_en) | ((nf | m_fall) & fall_en)) : '0;
        m_flag = setv | (m_flag & ~evt_clr);
        m_irq  = |m_flag;
        m_rise = nr;
        m_fall = nf;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pin_q", pin_q, m_q);
        chk("rise_p", rise_p, m_rise);
        chk("fall_p", fall_p, m_fall);
        chk("evt_flag", evt_flag, m_flag);
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
    endtask

    int           n;
    logic         found;
    logic [W-1:0] pulses;
    logic [W-1:0] held;

    initial begin
        rst_n = 1'b0; ena = 1'b1; pin_raw = '0;
        rise_en = '0; fall_en = '0; evt_clr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Quiet after reset
        repeat (30) step();
        chk("rst_pin_q", pin_q, 8'h00);
        chk("rst_flag", evt_flag, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);

        // Clean rising step on bit 0
        rise_en = 8'h01;
        pin_raw[0] = 1'b1;
        n = 99; found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            step();
            if (pin_q[0]) begin found = 1'b1; n = i; end
        end
        chk("lat_b0", 8'(n), 8'd18);
        chk("rise_b0", rise_p, 8'h01);
        chk("flag_b0", evt_flag, 8'h01);
        chk("irq_b0", {7'b0, irq}, 8'h01);
        step();
        chk("rise_b0_len", rise_p, 8'h00);

        // Short glitch on bit 3 is rejected
        pulses = '0;
        pin_raw[3] = 1'b1;
        repeat (10) begin step(); pulses |= rise_p | fall_p; end
        pin_raw[3] = 1'b0;
        repeat (30) begin step(); pulses |= rise_p | fall_p; end
        chk("glitch_q3", {7'b0, pin_q[3]}, 8'h00);
        chk("glitch_pulses", pulses, 8'h00);

        // Clear coinciding with a new rise loses; clear alone wins
        pin_raw[0] = 1'b0;
        repeat (20) step();
        chk("b0_low", {7'b0, pin_q[0]}, 8'h00);
        chk("b0_flag_kept", evt_flag, 8'h01);
        pin_raw[0] = 1'b1;
        found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            step();
            if (rise_p[0]) found = 1'b1;
        end
        chk("b0_rise_seen", {7'b0, found}, 8'h01);
        evt_clr = 8'h01;
        step();
        chk("set_wins", evt_flag, 8'h01);
        chk("set_wins_irq", {7'b0, irq}, 8'h01);
        step();
        chk("clr_alone", evt_flag, 8'h00);
        chk("clr_irq", {7'b0, irq}, 8'h00);
        evt_clr = 8'h00;

        // ena freeze mid-debounce on bit 5
        fall_en = 8'h20;
        pin_raw[5] = 1'b1;
        repeat (20) step();
        chk("b5_high", {7'b0, pin_q[5]}, 8'h01);
        pin_raw[5] = 1'b0;
        repeat (10) step();
        ena = 1'b0;
        pulses = '0; held = '1;
        repeat (20) begin step(); pulses |= rise_p | fall_p; held &= pin_q; end
        chk("frz_pulses", pulses, 8'h00);
        chk("frz_hold_b5", {7'b0, held[5]}, 8'h01);
        ena = 1'b1;
        n = 99; found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            step();
            if (fall_p[5]) begin found = 1'b1; n = i; end
        end
        chk("resume_lat", 8'(n), 8'd8);
        chk("resume_q5", {7'b0, pin_q[5]}, 8'h00);
        chk("resume_flag", evt_flag, 8'h20);

        // Asynchronous reset mid-count on bit 2
        pin_raw[2] = 1'b1;
        repeat (7) step();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_q", pin_q, 8'h00);
        chk("arst_rise", rise_p, 8'h00);
        chk("arst_fall", fall_p, 8'h00);
        chk("arst_flag", evt_flag, 8'h00);
        chk("arst_irq", {7'b0, irq}, 8'h00);
        #2 rst_n = 1'b1;
        n = 99; found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            step();
            if (pin_q[2]) begin found = 1'b1; n = i; end
        end
        chk("requal_b2", 8'(n), 8'd18);

        // Randomized pin activity
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 29) == 0) pin_raw[b] = ~pin_raw[b];
            end
            ena = ($urandom_range(0, 15) != 0);
            evt_clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            if (c % 100 == 0) begin
                rise_en = W'($urandom);
                fall_en = W'($urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
